// File: rtl/sort_input_packer.sv
// sort_input_packer: collects a valid/ready stream of WIDTH-bit elements into
// ELEMS-element words for the bitonic sorter. An assembly register gathers the
// current group while an output register presents the previous one. A group
// closed early by in_last has its unused upper slots filled with PAD_VALUE, so
// the pads sort to the top end.
module sort_input_packer #(
  parameter int               ELEMS     = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [ELEMS*WIDTH-1:0]       out_data,
  output logic [$clog2(ELEMS+1)-1:0]   out_count,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int IDX_W = $clog2(ELEMS);
  localparam int CNT_W = $clog2(ELEMS+1);

  typedef enum logic {COLLECT, PENDING} state_t;

  state_t                        state;
  logic [IDX_W-1:0]              index;
  logic [ELEMS-1:0][WIDTH-1:0]   asm_data;
  logic [CNT_W-1:0]              asm_count;

  logic [ELEMS-1:0][WIDTH-1:0]   grp_data;
  logic [CNT_W-1:0]              grp_count;
  logic                          accept;
  logic                          group_done;
  logic                          out_slot_free;

  // in_ready depends on state alone, so no path runs from out_ready to in_ready.
  assign in_ready      = (state == COLLECT);
  assign accept        = in_valid && in_ready;
  assign out_slot_free = !out_valid || out_ready;
  assign group_done    = (index == IDX_W'(ELEMS-1)) || in_last;
  assign grp_count     = CNT_W'(index) + CNT_W'(1);

  // Assembly group as it would look after this accept: the new element goes
  // into slot[index] and every higher slot holds PAD_VALUE. In an incomplete
  // group the pads are placeholders that later elements overwrite.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    grp_data = asm_data;
    for (int i = 0; i < ELEMS; i++) begin
      if (IDX_W'(i) == index)
        grp_data[i] = in_data;
      else if (IDX_W'(i) > index)
        grp_data[i] = PAD_VALUE;
    end
  end

  // Collect/pending control, assembly register and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the assembly register is reset as well, so no bytes from a group
      // cut off by reset can leak into a later group.
      state     <= COLLECT;
      index     <= '0;
      asm_data  <= '0;
      asm_count <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments only. A later load in this
      // block overrides the drop below, which gives back-to-back groups.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        COLLECT: begin
          if (accept) begin
            if (!group_done) begin
              asm_data <= grp_data;
              index    <= index + IDX_W'(1);
            end else if (out_slot_free) begin
              out_data  <= grp_data;
              out_count <= grp_count;
              out_valid <= 1'b1;
              index     <= '0;
            end else begin
              asm_data  <= grp_data;
              asm_count <= grp_count;
              state     <= PENDING;
            end
          end
        end
        PENDING: begin
          if (out_slot_free) begin
            out_data  <= asm_data;
            out_count <= asm_count;
            out_valid <= 1'b1;
            index     <= '0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/sort_input_packer.md
Name: sort_input_packer

Overview:
- Upstream feeder for the 4-element bitonic sorter.
- Accepts a byte-serial element stream with a valid/ready handshake and packs ELEMS consecutive elements into one ELEMS*WIDTH word.
- Presents each packed word to the sorter over a valid/ready handshake.
- Two-deep buffering (assembly register plus output register) lets the next group be collected while the sorter holds off. Short groups terminated by in_last are padded so they sort to the top end.

Parameters:
- ELEMS, 4, elements per packed group; must be >= 2.
- WIDTH, 8, bits per element.
- PAD_VALUE, {WIDTH{1'b1}}, fill value for unused slots of a short group. The maximum value sorts to the top in ascending order.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  element value
- in_valid  input  1  in_data/in_last are valid
- in_last  input  1  accepted element is the last of its group (may close a short group)
- in_ready  output  1  packer can accept an element this cycle
- out_data  output  ELEMS*WIDTH  packed group; element i occupies bits [i*WIDTH +: WIDTH], first received element = i=0
- out_count  output  $clog2(ELEMS+1)  number of real (non-pad) elements in out_data, 1..ELEMS
- out_valid  output  1  out_data/out_count hold a group for the sorter
- out_ready  input  1  sorter accepts the group this cycle

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (asynchronous assert, released synchronously by the environment):
  - State goes to COLLECT, index = 0, assembly register cleared.
  - out_valid=0, out_data=0, out_count=0; in_ready=1 once state is COLLECT.
  - Reset mid-operation discards any partial group and any held output group. Nothing is emitted for them.
- Transfers:
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - out_slot_free = !out_valid || out_ready, evaluated in the same cycle.
- State COLLECT (in_ready=1):
  - On accept, in_data is written to slot[index].
  - The group completes when index==ELEMS-1 or in_last=1. On completion, slots index+1..ELEMS-1 are forced to PAD_VALUE and count = index+1.
  - Not complete: index increments.
  - Complete and out_slot_free: the group (with pads) is loaded into the output register. out_valid=1 on the next edge, index=0, remain in COLLECT. Latency is 1 cycle from the final accept to out_valid.
  - Complete and not out_slot_free: move to PENDING. The assembly register keeps the group, including pads and count.
- State PENDING (in_ready=0):
  - When out_slot_free, the assembly group moves to the output register, index=0, and the state returns to COLLECT.
  - in_ready is combinational from state only. It is 1 in the cycle after the move, with no combinational path from out_ready.
- Output register:
  - out_data/out_count are stable while out_valid && !out_ready.
  - After a transfer, out_valid drops unless a new group loads in the same cycle. Back-to-back groups give no bubble.
- Ordering: groups are emitted strictly in arrival order. No element is dropped or duplicated.
- in_last on the element at index ELEMS-1 is a normal full group with count=ELEMS.
- in_last with no accepted element has no effect; empty groups do not exist.
- in_data/in_last are ignored when in_valid=0 or in_ready=0.
- Max occupancy is one output group plus one complete assembly group. in_ready=0 only in PENDING.

Test Plan:
- Full group, no backpressure: out_ready=1; send 0x30,0x10,0x40,0x20 on consecutive cycles -> out_valid rises 1 cycle after the 4th accept, out_data=0x20401030, out_count=4, out_valid for exactly 1 cycle.
- Short group: send 0x05,0x03 with in_last on 0x03 -> out_data=0xFFFF0305, out_count=2. A following 0x07 with in_last -> out_data=0xFFFFFF07, out_count=1.
- Backpressure: out_ready=0; send bytes 0x01..0x08 -> first group 0x04030201 held stable; in_ready=0 after the 8th accept (PENDING). Raise out_ready -> 0x04030201 then 0x08070605 on consecutive cycles, then in_ready=1.
- Simultaneous complete/drain: out_valid=1 holding group A; out_ready=1 in the same cycle the 4th byte of group B is accepted -> B appears on the next cycle with out_valid continuously 1 and no PENDING entry.
- Reset mid-group: accept 0x11,0x22, assert reset for 1 cycle while a group is also held at the output -> out_valid=0, out_data=0 immediately. Then 0xAA,0xBB,0xCC,0xDD -> out_data=0xDDCCBBAA, count 4, with no stale bytes.
- Random stream with random in_valid/out_ready/in_last (ELEMS=4 and ELEMS=8 builds) -> scoreboard matches packed groups, pads and counts exactly, and data is stable under stall.
